asmd_encryption: RTL and testbench

Iterative AES-128 encryption engine organised as an ASMD control unit plus datapath. It is the forward-direction counterpart of the team's decryption core. It accepts a 128-bit plaintext and cipher key on a start pulse and runs the 10 FIPS-197 rounds one transformation per cycle, expanding the key on the fly. It returns the ciphertext with a one-cycle `done` pulse. It sits beside the decryption core, and ciphertext from this block feeds that core directly.

---
 rtl/aes_pkg.sv | 90 +++++++++
 rtl/aes_key_expand_step.sv | 26 ++
 rtl/asmd_encryption_ctrl.sv | 55 +++++
 rtl/asmd_encryption_dp.sv | 85 ++++++++
 rtl/asmd_encryption.sv | 47 ++++
 tb/tb_asmd_encryption.sv | 327 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller state encoding, forward S-box, rcon and the
// forward round transformations. The decryption core reuses sbox, rcon_of and xtime.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        ROW  = 3'd2,
        COL  = 3'd3,
        ARK  = 3'd4,
        DONE = 3'd5
    } aes_state_e;

    localparam int unsigned NR = 10;

    // Entry 0 is the most significant byte, so SBOX[b] is S(b) directly.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) r[8*n +: 8] = sbox(s[8*n +: 8]);
        return r;
    endfunction

    // Byte n = row + 4*col sits at bits [127-8n -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One step of the AES-128 key schedule: derives the next round key from the current one.
module aes_key_expand_step
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_next
);

    logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    assign w0 = rk[127:96];
    assign w1 = rk[95:64];
    assign w2 = rk[63:32];
    assign w3 = rk[31:0];

    assign temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/asmd_encryption_ctrl.sv
// ASMD control unit: walks SUB/ROW/COL/ARK per round and raises the datapath enables.
module asmd_encryption_ctrl
    import aes_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic encrypt,
    input  logic count_eq_10,
    output logic init,
    output logic inc_count,
    output logic en_sub,
    output logic en_row,
    output logic en_col,
    output logic en_ark,
    output logic is_round10,
    output logic en_Dout,
    output logic done
);

    aes_state_e state_q, state_d;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no branch leaves state_d unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (encrypt) state_d = SUB;
            SUB:     state_d = ROW;
            ROW:     state_d = count_eq_10 ? ARK : COL;
            COL:     state_d = ARK;
            ARK:     state_d = count_eq_10 ? DONE : SUB;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        init       = (state_q == IDLE) && encrypt;
        en_sub     = (state_q == SUB);
        en_row     = (state_q == ROW);
        en_col     = (state_q == COL);
        en_ark     = (state_q == ARK);
        inc_count  = (state_q == ARK) && !count_eq_10;
        is_round10 = count_eq_10;
        // The final round result goes straight into Dout so it is valid alongside done.
        en_Dout    = (state_q == ARK) && count_eq_10;
        done       = (state_q == DONE);
    end

endmodule

// File: rtl/asmd_encryption_dp.sv
// Datapath: round state, per-step pipeline registers, on-the-fly round key and round counter.
module asmd_encryption_dp
    import aes_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] plain_text_in,
    input  logic [127:0] key_in,
    input  logic         init,
    input  logic         inc_count,
    input  logic         en_sub,
    input  logic         en_row,
    input  logic         en_col,
    input  logic         en_ark,
    input  logic         is_round10,
    input  logic         en_Dout,
    output logic         count_eq_10,
    output logic [127:0] Dout
);

    logic [127:0] state_q, state_d, sub_q, sub_d, row_q, row_d, col_q, col_d;
    logic [127:0] rk_q, rk_d, dout_q, dout_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] rk_next, ark_val;
    logic [7:0]   rcon_w;

    assign rcon_w      = rcon_of(round_q);
    assign count_eq_10 = (round_q == 4'(NR));
    // The last round skips MixColumns, so ARK takes ShiftRows output directly.
    assign ark_val     = (is_round10 ? row_q : col_q) ^ rk_q;
    assign Dout        = dout_q;

    aes_key_expand_step u_key_step (
        .rk      (rk_q),
        .rcon    (rcon_w),
        .rk_next (rk_next)
    );

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        row_d   = row_q;
        col_d   = col_q;
        rk_d    = rk_q;
        round_d = round_q;
        dout_d  = dout_q;
        if (init) begin
            state_d = plain_text_in ^ key_in;
            rk_d    = key_in;
            round_d = 4'd1;
        end
        if (en_sub) begin
            sub_d = sub_bytes(state_q);
            rk_d  = rk_next;
        end
        if (en_row) row_d = shift_rows(sub_q);
        if (en_col) col_d = mix_columns(row_q);
        if (en_ark) begin
            state_d = ark_val;
            if (inc_count) round_d = round_q + 4'd1;
        end
        if (en_Dout) dout_d = ark_val;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= '0;
            sub_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rk_q    <= '0;
            round_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: rtl/asmd_encryption.sv
// Iterative AES-128 encryption engine: ASMD control unit driving a one-step-per-cycle datapath.
module asmd_encryption (
    input  logic         clock,
    input  logic         reset,
    input  logic         encrypt,
    input  logic [127:0] plain_text_in,
    input  logic [127:0] key_in,
    output logic [127:0] Dout,
    output logic         done
);

    logic init, inc_count, en_sub, en_row, en_col, en_ark, is_round10, en_Dout, count_eq_10;

    asmd_encryption_ctrl u_ctrl (
        .clock       (clock),
        .reset       (reset),
        .encrypt     (encrypt),
        .count_eq_10 (count_eq_10),
        .init        (init),
        .inc_count   (inc_count),
        .en_sub      (en_sub),
        .en_row      (en_row),
        .en_col      (en_col),
        .en_ark      (en_ark),
        .is_round10  (is_round10),
        .en_Dout     (en_Dout),
        .done        (done)
    );

    asmd_encryption_dp u_dp (
        .clock         (clock),
        .reset         (reset),
        .plain_text_in (plain_text_in),
        .key_in        (key_in),
        .init          (init),
        .inc_count     (inc_count),
        .en_sub        (en_sub),
        .en_row        (en_row),
        .en_col        (en_col),
        .en_ark        (en_ark),
        .is_round10    (is_round10),
        .en_Dout       (en_Dout),
        .count_eq_10   (count_eq_10),
        .Dout          (Dout)
    );

endmodule

// File: tb/tb_asmd_encryption.sv
// Self-checking bench for asmd_encryption: FIPS-197 vectors, random vectors against a
// byte-array AES model with a computed S-box, and multi-cycle control corner cases.
module tb_asmd_encryption;
    import aes_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         encrypt = 1'b0;
    logic [127:0] plain_text_in = '0;
    logic [127:0] key_in = '0;
    logic [127:0] Dout;
    logic         done;

    asmd_encryption dut (
        .clock         (clock),
        .reset         (reset),
        .encrypt       (encrypt),
        .plain_text_in (plain_text_in),
        .key_in        (key_in),
        .Dout          (Dout),
        .done          (done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  sbox_m     [256];
    logic [7:0]  inv_sbox_m [256];
    logic [31:0] w_m        [44];

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s, b;
        for (int i = 0; i < 256; i++) begin
            b   = 8'(i);
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_m[i]     = s;
            inv_sbox_m[s] = b;
        end
    endtask

    function automatic void expand_key(input logic [127:0] key);
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w_m[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w_m[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w_m[i] = w_m[i-4] ^ tmp;
        end
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] out;
        expand_key(key);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w_m[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = sbox_m[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = (rnd < 10)
                        ? gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c]
                        : t[r][c];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = s[r][c] ^ w_m[4*rnd+c][31-8*r -: 8];
        end
        out = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[127-8*(r+4*c) -: 8] = s[r][c];
        return out;
    endfunction

    // Inverse cipher standing in for the decryption core on the loopback path.
    function automatic logic [127:0] model_dec(input logic [127:0] key, input logic [127:0] ct);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] out;
        expand_key(key);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127-8*(r+4*c) -: 8] ^ w_m[40+c][31-8*r -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = inv_sbox_m[s[r][(c-r+4)%4]] ^ w_m[4*rnd+c][31-8*r -: 8];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = (rnd > 0)
                        ? gmul(8'h0e, t[r][c]) ^ gmul(8'h0b, t[(r+1)%4][c])
                          ^ gmul(8'h0d, t[(r+2)%4][c]) ^ gmul(8'h09, t[(r+3)%4][c])
                        : t[r][c];
        end
        out = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[127-8*(r+4*c) -: 8] = s[r][c];
        return out;
    endfunction

    // One encryption: returns ciphertext, cycles from start edge to done, and rk after round-1 SUB.
    task automatic run_enc(input logic [127:0] key, input logic [127:0] pt,
                           output logic [127:0] ct, output int lat, output logic [127:0] rk1);
        @(negedge clock);
        key_in        = key;
        plain_text_in = pt;
        encrypt       = 1'b1;
        @(posedge clock);
        #1;
        encrypt = 1'b0;
        lat = -1;
        ct  = '0;
        rk1 = '0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            #1;
            if (i == 1) rk1 = dut.u_dp.rk_q;
            if (done) begin
                lat = i;
                ct  = Dout;
                break;
            end
        end
        @(posedge clock);
        #1;
        check("done_width", 128'(done), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] ct, rk1, k, p, c1, c2;
        int           lat, nd, t1, t2;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        build_sbox();

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_done",  128'(done), 128'd0);
        check("rst_dout",  Dout, 128'd0);
        check("rst_round", 128'(dut.u_dp.round_q), 128'd0);
        check("rst_state", 128'(dut.u_ctrl.state_q), 128'(IDLE));
        @(negedge clock);
        reset = 1'b1;

        // Known-answer vectors
        for (int i = 0; i < 3; i++) begin
            run_enc(vecs[i].key, vecs[i].pt, ct, lat, rk1);
            check($sformatf("kat%0d_ct", i), ct, vecs[i].ct);
            check($sformatf("kat%0d_latency", i), 128'(lat), 128'd39);
            check($sformatf("kat%0d_loopback", i), model_dec(vecs[i].key, ct), vecs[i].pt);
            if (i == 1) check("kat1_rk_round1", rk1, 128'ha0fafe1788542cb123a339392a6c7605);
        end

        // Random vectors against the reference model
        for (int i = 0; i < 6; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            run_enc(k, p, ct, lat, rk1);
            check($sformatf("rand%0d_ct", i), ct, model_enc(k, p));
            check($sformatf("rand%0d_loopback", i), model_dec(k, ct), p);
        end

        // encrypt re-pulsed and inputs changed mid-operation
        @(negedge clock);
        key_in        = vecs[1].key;
        plain_text_in = vecs[1].pt;
        encrypt       = 1'b1;
        @(posedge clock);
        #1;
        encrypt = 1'b0;
        lat = -1;
        ct  = '0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            #1;
            if (i == 10) begin
                encrypt       = 1'b1;
                plain_text_in = ~plain_text_in;
                key_in        = '1;
            end
            if (i == 11) encrypt = 1'b0;
            if (done) begin
                lat = i;
                ct  = Dout;
                break;
            end
        end
        check("midop_ct", ct, vecs[1].ct);
        check("midop_latency", 128'(lat), 128'd39);
        nd = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clock);
            #1;
            if (done) nd++;
        end
        check("midop_no_extra_done", 128'(nd), 128'd0);

        // encrypt held high: back-to-back runs every 41 cycles, second one with a new plaintext
        @(negedge clock);
        key_in        = vecs[0].key;
        plain_text_in = vecs[0].pt;
        encrypt       = 1'b1;
        @(posedge clock);
        #1;
        nd = 0;
        t1 = -1;
        t2 = -1;
        c1 = '0;
        c2 = '0;
        for (int i = 1; i <= 90; i++) begin
            @(posedge clock);
            #1;
            if (i == 5) plain_text_in = vecs[1].pt;
            if (done) begin
                if (nd == 0) begin
                    t1 = i;
                    c1 = Dout;
                end else begin
                    t2 = i;
                    c2 = Dout;
                end
                nd++;
                if (nd == 2) break;
            end
        end
        encrypt = 1'b0;
        check("held_first_time",  128'(t1), 128'd39);
        check("held_first_ct",    c1, vecs[0].ct);
        check("held_second_time", 128'(t2), 128'd80);
        check("held_second_ct",   c2, model_enc(vecs[0].key, vecs[1].pt));
        repeat (2) @(posedge clock);

        // Reset asserted at cycle 20 of an operation
        @(negedge clock);
        key_in        = vecs[2].key;
        plain_text_in = vecs[2].pt;
        encrypt       = 1'b1;
        @(posedge clock);
        #1;
        encrypt = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("abort_state", 128'(dut.u_ctrl.state_q), 128'(IDLE));
        check("abort_dout",  Dout, 128'd0);
        check("abort_done",  128'(done), 128'd0);
        check("abort_round", 128'(dut.u_dp.round_q), 128'd0);
        check("abort_rk",    dut.u_dp.rk_q, 128'd0);
        reset = 1'b1;
        nd = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            if (done) nd++;
        end
        check("abort_no_done", 128'(nd), 128'd0);
        run_enc(vecs[0].key, vecs[0].pt, ct, lat, rk1);
        check("after_abort_ct", ct, vecs[0].ct);
        check("after_abort_latency", 128'(lat), 128'd39);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
